// File: rtl/frame_rotation_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_rotation_ctrl_pkg
// Description : Shared state encodings and widths for the frame rotation
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_rotation_ctrl_pkg;

    typedef logic [1:0] fr_state_t;

    localparam fr_state_t FR_COLLECT = 2'd0;
    localparam fr_state_t FR_READY   = 2'd1;
    localparam fr_state_t FR_ROTATE  = 2'd2;
    localparam fr_state_t FR_START   = 2'd3;

    // Width of the missed-vsync counter in watchdog builds.
    localparam int MISSED_W = 4;

endpackage
`default_nettype wire

// File: rtl/frame_rotation_ctrl_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : frame_rotation_ctrl_edge_detect
// Description : Registered falling-edge detector; o_fall is high in the first
//               cycle that i_sig is low after being high.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_rotation_ctrl_edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_sig,
    output logic o_fall
);

    logic r_sig_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sig_q <= RESET_VAL;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    assign o_fall = r_sig_q & ~i_sig;

endmodule
`default_nettype wire

// File: rtl/frame_rotation_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frame_rotation_ctrl
// Description : Four-buffer SRAM rotation scheduler. Collects per-stage frame
//               completions, rotates on VGA vsync fall, then restarts stages.
//               Build option FRAME_ROT_WATCHDOG_EN adds forced rotation.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_rotation_ctrl
    import frame_rotation_ctrl_pkg::*;
#(
    parameter int MAX_MISSED = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ntsc_frame_done,
    input  logic             lpf_frame_done,
    input  logic             ptf_frame_done,
    input  logic             vsync,
    input  logic             enable,
    output logic             frame_flag,
    output logic             stage_start,
    output logic             forced_rot,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] drop_count,
    output logic [1:0]       state_dbg
);

    if (MAX_MISSED < 1 || MAX_MISSED > 15) begin : g_max_missed_range
        $error("frame_rotation_ctrl: MAX_MISSED must be within 1..15");
    end

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    fr_state_t        r_state;
    fr_state_t        w_state_nxt;
    logic             r_got_ntsc;
    logic             r_got_lpf;
    logic             r_got_ptf;
    logic             w_vs_fall;
    logic             w_all_done;
    logic             w_drop;
    logic             w_frame_flag_nxt;
    logic             w_stage_start_nxt;
    logic             r_frame_flag;
    logic             r_stage_start;
    logic [CNT_W-1:0] r_frame_count;
    logic [CNT_W-1:0] r_drop_count;

`ifdef FRAME_ROT_WATCHDOG_EN
    localparam logic [MISSED_W-1:0] c_miss_limit = MISSED_W'(MAX_MISSED - 1);

    logic [MISSED_W-1:0] r_missed;
    logic                w_force;
    logic                w_miss;
    logic                r_forced_rot;
`endif

    frame_rotation_ctrl_edge_detect #(
        .RESET_VAL (1'b1)
    ) u_vsync_edge (
        .clock  (clock),
        .reset  (reset),
        .i_sig  (vsync),
        .o_fall (w_vs_fall)
    );

    // A completion arriving in the same cycle as the check still counts.
    assign w_all_done = (r_got_ntsc | ntsc_frame_done) &
                        (r_got_lpf  | lpf_frame_done)  &
                        (r_got_ptf  | ptf_frame_done);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= FR_COLLECT;
            r_frame_flag  <= 1'b0;
            r_stage_start <= 1'b0;
`ifdef FRAME_ROT_WATCHDOG_EN
            r_forced_rot  <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_frame_flag  <= w_frame_flag_nxt;
            r_stage_start <= w_stage_start_nxt;
`ifdef FRAME_ROT_WATCHDOG_EN
            r_forced_rot  <= w_force;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drop      = 1'b0;
`ifdef FRAME_ROT_WATCHDOG_EN
        w_force     = 1'b0;
        w_miss      = 1'b0;
`endif
        case (r_state)
            FR_COLLECT: begin
                if (w_all_done) begin
                    w_state_nxt = FR_READY;
                end else if (w_vs_fall) begin
                    w_drop = 1'b1;
`ifdef FRAME_ROT_WATCHDOG_EN
                    // Holding at the limit keeps a disabled display armed for
                    // a forced rotation as soon as enable returns.
                    if (enable && (r_missed == c_miss_limit)) begin
                        w_state_nxt = FR_ROTATE;
                        w_force     = 1'b1;
                    end else if (r_missed != c_miss_limit) begin
                        w_miss = 1'b1;
                    end
`endif
                end
            end
            FR_READY: begin
                if (w_vs_fall) begin
                    if (enable) begin
                        w_state_nxt = FR_ROTATE;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            FR_ROTATE: w_state_nxt = FR_START;
            FR_START:  w_state_nxt = FR_COLLECT;
            default:   w_state_nxt = FR_COLLECT;
        endcase
    end

    always_comb begin
        w_frame_flag_nxt  = (w_state_nxt == FR_ROTATE);
        w_stage_start_nxt = (w_state_nxt == FR_START);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_got_ntsc    <= 1'b0;
            r_got_lpf     <= 1'b0;
            r_got_ptf     <= 1'b0;
            r_frame_count <= '0;
            r_drop_count  <= '0;
`ifdef FRAME_ROT_WATCHDOG_EN
            r_missed      <= '0;
`endif
        end else begin
            if (w_state_nxt == FR_ROTATE) begin
                r_got_ntsc <= 1'b0;
                r_got_lpf  <= 1'b0;
                r_got_ptf  <= 1'b0;
            end else if ((r_state == FR_COLLECT) || (r_state == FR_READY)) begin
                r_got_ntsc <= r_got_ntsc | ntsc_frame_done;
                r_got_lpf  <= r_got_lpf  | lpf_frame_done;
                r_got_ptf  <= r_got_ptf  | ptf_frame_done;
            end

            if (r_state == FR_ROTATE) begin
                r_frame_count <= r_frame_count + 1'b1;
            end

            if (w_drop && (r_drop_count != c_cnt_max)) begin
                r_drop_count <= r_drop_count + 1'b1;
            end

`ifdef FRAME_ROT_WATCHDOG_EN
            if (r_state == FR_ROTATE) begin
                r_missed <= '0;
            end else if (w_miss) begin
                r_missed <= r_missed + 1'b1;
            end
`endif
        end
    end

    assign frame_flag  = r_frame_flag;
    assign stage_start = r_stage_start;
    assign frame_count = r_frame_count;
    assign drop_count  = r_drop_count;
    assign state_dbg   = r_state;
`ifdef FRAME_ROT_WATCHDOG_EN
    assign forced_rot  = r_forced_rot;
`else
    assign forced_rot  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_rotation_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_rotation_ctrl
// Description : Scoreboard bench for frame_rotation_ctrl; stimulus queues the
//               expected rotations and a monitor checks each one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_rotation_ctrl;

    typedef struct {
        int         cyc;
        bit         forced;
        bit         ss;
        logic [7:0] fc_before;
        logic [7:0] fc_after;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       ntsc, lpf, ptf, vsync, enable;
    logic       frame_flag, stage_start, forced_rot;
    logic [7:0] frame_count, drop_count;
    logic [1:0] state_dbg;

    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         t0;
    logic [7:0] fc_exp;
    exp_t       q[$];

    frame_rotation_ctrl #(
        .MAX_MISSED (4),
        .CNT_W      (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ntsc_frame_done (ntsc),
        .lpf_frame_done  (lpf),
        .ptf_frame_done  (ptf),
        .vsync           (vsync),
        .enable          (enable),
        .frame_flag      (frame_flag),
        .stage_start     (stage_start),
        .forced_rot      (forced_rot),
        .frame_count     (frame_count),
        .drop_count      (drop_count),
        .state_dbg       (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic go(input int c);
        while (cyc < c) step();
    endtask

    task automatic pulse(input bit n, input bit l, input bit p);
        ntsc = n; lpf = l; ptf = p;
        step();
        ntsc = 1'b0; lpf = 1'b0; ptf = 1'b0;
    endtask

    // Drives vsync low for one cycle; a rotation is expected in the next cycle.
    task automatic vs_edge(input bit rot, input bit forced, input bit ss);
        exp_t e;
        vsync = 1'b0;
        if (rot) begin
            e.cyc       = cyc + 1;
            e.forced    = forced;
            e.ss        = ss;
            e.fc_before = fc_exp;
            e.fc_after  = fc_exp + 8'd1;
            q.push_back(e);
            fc_exp = fc_exp + 8'd1;
        end
        step();
        vsync = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ntsc = 1'b0; lpf = 1'b0; ptf = 1'b0; vsync = 1'b1; enable = 1'b1;
        repeat (2) step();
        reset  = 1'b0;
        fc_exp = 8'd0;
        t0     = cyc;
    endtask

    // Monitor: pops expected rotations and checks the flag/start/count timing.
    initial begin : monitor
        exp_t e;
        bit   have_ss = 1'b0;
        int   ss_cyc  = 0;
        bit   ss_exp  = 1'b0;
        int   ss_fc   = 0;
        forever begin
            @(negedge clock);
            if (have_ss && (cyc == ss_cyc)) begin
                check("stage_start", int'(stage_start), int'(ss_exp));
                if (ss_exp) check("frame_count_after", int'(frame_count), ss_fc);
                have_ss = 1'b0;
            end else if (stage_start) begin
                check("stage_start_unexpected", int'(stage_start), 0);
            end
            if ((q.size() > 0) && (q[0].cyc == cyc)) begin
                e = q.pop_front();
                check("frame_flag", int'(frame_flag), 1);
                check("forced_rot", int'(forced_rot), int'(e.forced));
                check("frame_count_at_flag", int'(frame_count), int'(e.fc_before));
                have_ss = 1'b1;
                ss_cyc  = cyc + 1;
                ss_exp  = e.ss;
                ss_fc   = int'(e.fc_after);
            end else if (frame_flag || forced_rot) begin
                check("frame_flag_unexpected", int'({frame_flag, forced_rot}), 0);
            end
        end
    end

    initial begin : timeout
        #1000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset = 1'b1;
        ntsc = 1'b0; lpf = 1'b0; ptf = 1'b0; vsync = 1'b1; enable = 1'b1;
        fc_exp = 8'd0;

        // Reset values
        do_reset();
        check("rst_frame_flag",  int'(frame_flag), 0);
        check("rst_stage_start", int'(stage_start), 0);
        check("rst_forced_rot",  int'(forced_rot), 0);
        check("rst_frame_count", int'(frame_count), 0);
        check("rst_drop_count",  int'(drop_count), 0);
        check("rst_state",       int'(state_dbg), 0);

        // Staggered completions, rotation on vsync at 100
        go(t0 + 10); pulse(1, 0, 0);
        go(t0 + 20); pulse(0, 1, 0);
        go(t0 + 30);
        check("collect_before_last", int'(state_dbg), 0);
        pulse(0, 0, 1);
        check("ready_at_31", int'(state_dbg), 1);
        go(t0 + 100);
        vs_edge(1, 0, 1);
        check("rotate_state", int'(state_dbg), 2);
        step(); step();
        check("back_to_collect", int'(state_dbg), 0);
        check("basic_drop", int'(drop_count), 0);
        check("basic_queue", q.size(), 0);

        // Missing ptf: three dropped edges, then rotation
        do_reset();
        pulse(1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            vs_edge(0, 0, 1);
            step();
        end
        check("drop3", int'(drop_count), 3);
        check("drop3_state", int'(state_dbg), 0);
        pulse(0, 0, 1);
        check("late_ptf_ready", int'(state_dbg), 1);
        vs_edge(1, 0, 1);
        repeat (3) step();
        check("drop3_hold", int'(drop_count), 3);
        check("drop3_queue", q.size(), 0);

        // enable low in READY
        do_reset();
        pulse(1, 1, 1);
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vs_edge(0, 0, 1);
            step();
        end
        check("disabled_drop", int'(drop_count), 2);
        check("disabled_ready", int'(state_dbg), 1);
        enable = 1'b1;
        vs_edge(1, 0, 1);
        repeat (3) step();
        check("enable_queue", q.size(), 0);

        // Completion and vsync fall in the same cycle: READY, no rotation
        do_reset();
        pulse(1, 1, 0);
        vsync = 1'b0;
        pulse(0, 0, 1);
        vsync = 1'b1;
        check("same_cycle_ready", int'(state_dbg), 1);
        check("same_cycle_drop", int'(drop_count), 0);
        step();
        vs_edge(1, 0, 1);
        repeat (3) step();
        check("same_cycle_queue", q.size(), 0);

        // Four edges with no completions
        do_reset();
        for (int i = 0; i < 4; i++) begin
`ifdef FRAME_ROT_WATCHDOG_EN
            vs_edge(i == 3, 1, 1);
`else
            vs_edge(0, 0, 1);
`endif
            step();
        end
        repeat (3) step();
        check("watchdog_drop", int'(drop_count), 4);
        check("watchdog_state", int'(state_dbg), 0);
        check("watchdog_queue", q.size(), 0);

        // ptf during frame_flag is discarded
        do_reset();
        pulse(1, 1, 1);
        vs_edge(1, 0, 1);
        pulse(0, 0, 1);
        step();
        pulse(1, 1, 0);
        check("discarded_ptf", int'(state_dbg), 0);
        pulse(0, 0, 1);
        check("ptf_after_start", int'(state_dbg), 1);
        // Reset while START is presented
        vs_edge(1, 0, 1);
        step();
        reset = 1'b1;
        step();
        reset  = 1'b0;
        fc_exp = 8'd0;
        check("rst_start_count", int'(frame_count), 0);
        check("rst_start_state", int'(state_dbg), 0);
        check("rst_start_ss",    int'(stage_start), 0);
        // Reset during ROTATE aborts the stage_start
        pulse(1, 1, 1);
        vs_edge(1, 0, 0);
        reset = 1'b1;
        step();
        reset  = 1'b0;
        fc_exp = 8'd0;
        repeat (4) step();
        check("abort_state", int'(state_dbg), 0);
        check("abort_count", int'(frame_count), 0);
        check("abort_queue", q.size(), 0);

        // 300 rotations wrap frame_count
        do_reset();
        for (int i = 0; i < 300; i++) begin
            pulse(1, 1, 1);
            vs_edge(1, 0, 1);
            repeat (2) step();
        end
        step();
        check("wrap_count", int'(frame_count), 44);
        check("wrap_queue", q.size(), 0);

        // drop_count saturation (enable low prevents any forced rotation)
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < 254; i++) begin
            vs_edge(0, 0, 1);
            step();
        end
        check("drop_254", int'(drop_count), 254);
        for (int i = 0; i < 6; i++) begin
            vs_edge(0, 0, 1);
            step();
        end
        check("drop_sat", int'(drop_count), 255);
        check("drop_sat_state", int'(state_dbg), 0);
        enable = 1'b1;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_rotation_ctrl.md
# frame_rotation_ctrl

Frame-level scheduler for the four-buffer SRAM rotation (capture, process, next-display, display). It collects per-stage "frame complete" pulses from NTSC capture, LPF and the projective-transform fetcher. It then waits for the start of VGA vertical sync and issues the single-cycle `frame_flag` that rotates buffer roles in `memory_interface`, followed by a restart pulse to the processing stages. It also keeps frame and dropped-frame statistics for debug.

## Interface
- `MAX_MISSED`, 4: vsync edges tolerated in COLLECT before a forced rotation (watchdog builds only); legal range 1..15.
- `CNT_W`, 8: width of `frame_count` and `drop_count`.

- `clock` in 1: system clock; sole clock.
- `reset` in 1: synchronous, active-high.
- `ntsc_frame_done` in 1: one-cycle pulse; capture finished writing a frame.
- `lpf_frame_done` in 1: one-cycle pulse; LPF finished a frame.
- `ptf_frame_done` in 1: one-cycle pulse; projective fetcher finished a frame.
- `vsync` in 1: VGA vsync, active-low, synchronous to `clock`.
- `enable` in 1: rotation permitted when 1; 0 freezes the current display.
- `frame_flag` out 1: one-cycle rotate command to `memory_interface`.
- `stage_start` out 1: one-cycle restart pulse to capture, LPF and fetcher.
- `forced_rot` out 1: one-cycle pulse coincident with a watchdog-forced `frame_flag`.
- `frame_count` out CNT_W: rotations issued; wraps.
- `drop_count` out CNT_W: vsync edges that did not rotate; saturates at all-ones.
- `state_dbg` out 2: current FSM state encoding.

## Operation
- Vsync edge: `vsync_q` registers `vsync`. `vs_fall = vsync_q & ~vsync`.
- Sticky bits: `got_ntsc`, `got_lpf` and `got_ptf` set on their pulses in COLLECT and READY. They are cleared on entry to ROTATE. Pulses during ROTATE and START are discarded.
- `all_done` = (sticky | same-cycle pulse) for all three stages.
- FSM states:
  - COLLECT:
    - `all_done` → READY.
    - `vs_fall` with `all_done` = 0 → `drop_count`++ and `missed`++.
    - Watchdog build only: `vs_fall` && `enable` && `missed` == MAX_MISSED-1 → ROTATE (forced).
  - READY:
    - `vs_fall` && `enable` → ROTATE.
    - `vs_fall` && !`enable` → `drop_count`++, stay in READY. `missed` is not advanced.
  - ROTATE: `frame_flag`=1; `frame_count`++; `missed` ← 0; sticky bits cleared → START.
  - START: `stage_start`=1 → COLLECT.
- A `vs_fall` in ROTATE or START is ignored and not counted.
- `done` and `vs_fall` in the same cycle in COLLECT: the pulse counts, so `all_done` may be 1 and the state goes to READY. It does not rotate on that edge.

## Timing
- All outputs are registered.
- Reset values:
  - Outputs: `frame_flag`, `stage_start`, `forced_rot` = 0; `frame_count`, `drop_count` = 0; `state_dbg` = COLLECT.
  - Internal: `vsync_q` = 1; sticky bits = 0; `missed` = 0.
- Reset mid-rotation aborts the sequence: no further `frame_flag` or `stage_start` is emitted.
- Completing pulse at cycle t → READY at t+1.
- `vs_fall` at cycle t in READY → `frame_flag` high during t+1 only, `stage_start` high during t+2 only, COLLECT at t+3.
- `frame_count` shows the new value at t+2.
- Minimum spacing between `frame_flag` pulses: 3 cycles; in practice one vsync period.

## Configuration
- `FRAME_ROT_WATCHDOG_EN` defined: forced-rotation path and `forced_rot` are present, and `missed` is 4 bits.
- Undefined: `forced_rot` is tied 0, `missed` is removed, and COLLECT waits indefinitely for all three stages. `drop_count` still increments.

## Structure
- State encodings belong in `params.v` as shared defines: `FR_COLLECT`=0, `FR_READY`=1, `FR_ROTATE`=2, `FR_START`=3.
- One natural sub-module, `edge_detect`: a registered falling-edge detector, reused for `vsync`.

## Test plan
- Reset, then pulses on ntsc, lpf and ptf at cycles 10, 20 and 30, then vsync falls at cycle 100 → READY at 31; `frame_flag` at 101, `stage_start` at 102; `frame_count`=1.
- Only ntsc and lpf done, then 3 vsync falls → no `frame_flag`; `drop_count`=3. The ptf pulse arrives, then the next fall → rotation; `frame_count`=1.
- With `enable`=0 in READY, 2 vsync falls → `drop_count`=2, no rotation. Raise `enable`, next fall → rotation.
- Watchdog build, MAX_MISSED=4, no done pulses, 4 vsync falls → `frame_flag` and `forced_rot` one cycle after the 4th edge; `drop_count`=4.
- A `ptf_frame_done` pulse during the `frame_flag` cycle is discarded: after START, sticky bits are all 0. Assert `reset` in START → all outputs 0, state COLLECT.
- 300 rotations → `frame_count` wraps to 44. Force 260 drops → `drop_count` holds at 255.
